iob_ram_tdp_be_pipe: RTL
========================

IOB_RAM_TDP_BE_PIPE -- requirements
Module: iob_ram_tdp_be_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, word width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 6, address width; the memory holds 2**ADDR_W words.
REQ-003 The block SHALL have parameter READ_LAT, default 1, read latency in cycles; the legal values are 1 and 2.
REQ-004 The block SHALL have parameter WRITE_FIRST, default 0: 0 selects same-port read-first, 1 selects same-port write-first.
REQ-005 The block SHALL have parameter INIT_ZERO, default 1: 1 zero-fills the memory after reset.
REQ-006 The block SHALL use one clock and synchronous, active-high reset; ports clk_i and rst_i.
REQ-007 Ports SHALL be (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- ready_o  out  1  memory is accepting accesses.
- enA_i  in  1  port A access enable.
- weA_i  in  DATA_W/8  port A byte write enables.
- addrA_i  in  ADDR_W  port A address.
- dA_i  in  DATA_W  port A write data.
- dA_o  out  DATA_W  port A read data.
- validA_o  out  1  dA_o updated this cycle.
- enB_i, weB_i, addrB_i, dB_i, dB_o, validB_o: same widths and meanings as port A, for port B.

Function
REQ-008 The control FSM SHALL have states RST, INIT and RDY; rst_i high forces RST from any state.
REQ-009 RST SHALL go to INIT when INIT_ZERO=1, and to RDY otherwise, on the first clock with rst_i low.
REQ-010 In INIT, a counter SHALL write 0 to address 0..2**ADDR_W-1, one address per cycle, then go to RDY.
REQ-011 ready_o SHALL be 1 only in RDY.
REQ-012 While ready_o=0, port accesses SHALL be ignored: no memory write and no valid pulse.
REQ-013 An access SHALL be accepted when enX_i=1 and ready_o=1 on a clock edge.
REQ-014 On an accepted access, the bytes with weX_i[k]=1 SHALL be written; weX_i=0 makes the access a pure read.
REQ-015 Every accepted access SHALL assert validX_o exactly READ_LAT cycles later, for one cycle, with dX_o updated in the same cycle.
REQ-016 The data returned SHALL be the word at addrX_i before the edge when WRITE_FIRST=0, and the byte-merged new word when WRITE_FIRST=1.
REQ-017 When READ_LAT=2, the block SHALL add one output register stage; back-to-back accesses SHALL sustain 1 access/cycle/port.
REQ-018 dX_o SHALL hold its last value when no valid pulse occurs.
REQ-019 When both ports write the same address in the same cycle, port A SHALL win each byte enabled by both ports, and bytes enabled only by B SHALL take B's data.
REQ-020 A port reading an address that the other port writes in the same cycle SHALL return the old word, in either WRITE_FIRST mode.
REQ-021 An address wraps only by width; every address value is legal.

Reset
REQ-022 rst_i=1 SHALL clear dA_o, dB_o, validA_o, validB_o, ready_o and the INIT counter to 0, and flush in-flight reads (no valid pulse after reset).
REQ-023 Reset SHALL NOT alter memory contents when INIT_ZERO=0; when INIT_ZERO=1, a reset during INIT SHALL restart the sweep at address 0.

Structure
REQ-024 The FSM state encodings (RST=0, INIT=1, RDY=2) SHALL live in the shared package iob_ram_tdp_be_pipe_pkg, together with the READ_LAT legality check.
REQ-025 The storage array and per-port byte-write logic SHALL be one sub-module, iob_ram_tdp_be_core; the FSM, collision merge and output pipeline SHALL be in the top module.

Verification
All scenarios use DATA_W=32, ADDR_W=4.
REQ-026 Reset release with INIT_ZERO=1 -> ready_o=0 for 16 cycles, then 1; a read of address 7 with READ_LAT=1 -> validA_o after 1 cycle, dA_o=0x00000000.
REQ-027 Port A writes 0x11223344 to address 3 (weA_i=0xF), then weA_i=0x2 with dA_i=0xAABBCCDD; a port B read of address 3 -> dB_o=0x1122CC44.
REQ-028 Same-cycle write to address 5: A writes 0xAAAAAAAA with weA_i=0x3, B writes 0xBBBBBBBB with weB_i=0x6 -> the word reads 0x00BBAAAA (from zero-init).
REQ-029 WRITE_FIRST=0 vs 1: address 2 holds 0x5; port A writes 0x9 to address 2 -> dA_o=0x5 vs 0x9, while port B reading address 2 in the same cycle gets 0x5 in both modes.
REQ-030 READ_LAT=2: 16 back-to-back reads on port B -> 16 consecutive validB_o pulses starting 2 cycles after the first access, data in order.
REQ-031 rst_i asserted mid-INIT at count 8, with memory pre-filled and INIT_ZERO=1 -> the sweep restarts, ready_o rises 16 cycles after release, and every address reads 0.

Source files
------------

// File: rtl/iob_ram_tdp_be_pipe_pkg.sv
// Shared definitions for the true-dual-port byte-enable RAM: control FSM
// encodings and the read-latency legality check.
package iob_ram_tdp_be_pipe_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_INIT = 2'd1,
    ST_RDY  = 2'd2
  } state_t;

  function automatic bit read_lat_ok(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/iob_ram_tdp_be_core.sv
// Storage array with two byte-enabled write ports and two asynchronous read
// ports; overlapping same-address enables are resolved by the caller.
module iob_ram_tdp_be_core
  import iob_ram_tdp_be_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                  clk_i,
  input  logic [DATA_W/8-1:0]   weA_i,
  input  logic [ADDR_W-1:0]     addrA_i,
  input  logic [DATA_W-1:0]     dA_i,
  output logic [DATA_W-1:0]     rdA_o,
  input  logic [DATA_W/8-1:0]   weB_i,
  input  logic [ADDR_W-1:0]     addrB_i,
  input  logic [DATA_W-1:0]     dB_i,
  output logic [DATA_W-1:0]     rdB_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < DATA_W/BYTE_W; k++) begin
      if (weA_i[k]) mem[addrA_i][BYTE_W*k +: BYTE_W] <= dA_i[BYTE_W*k +: BYTE_W];
      if (weB_i[k]) mem[addrB_i][BYTE_W*k +: BYTE_W] <= dB_i[BYTE_W*k +: BYTE_W];
    end
  end

  assign rdA_o = mem[addrA_i];
  assign rdB_o = mem[addrB_i];

endmodule

// File: rtl/iob_ram_tdp_be_pipe.sv
// True-dual-port byte-enable RAM with zero-fill sweep after reset, same-port
// read-/write-first selection, A-priority collision merge and 1- or 2-cycle reads.
module iob_ram_tdp_be_pipe
  import iob_ram_tdp_be_pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned WRITE_FIRST = 0,
  parameter int unsigned INIT_ZERO   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  ready_o,
  input  logic                  enA_i,
  input  logic [DATA_W/8-1:0]   weA_i,
  input  logic [ADDR_W-1:0]     addrA_i,
  input  logic [DATA_W-1:0]     dA_i,
  output logic [DATA_W-1:0]     dA_o,
  output logic                  validA_o,
  input  logic                  enB_i,
  input  logic [DATA_W/8-1:0]   weB_i,
  input  logic [ADDR_W-1:0]     addrB_i,
  input  logic [DATA_W-1:0]     dB_i,
  output logic [DATA_W-1:0]     dB_o,
  output logic                  validB_o
);

  localparam int unsigned NB = DATA_W/BYTE_W;

  if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
    $error("iob_ram_tdp_be_pipe: READ_LAT must be 1 or 2");
  end
  if (DATA_W % BYTE_W != 0) begin : g_bad_width
    $error("iob_ram_tdp_be_pipe: DATA_W must be a multiple of 8");
  end

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [NB-1:0]     be);
    byte_merge = old_w;
    for (int unsigned k = 0; k < NB; k++)
      if (be[k]) byte_merge[BYTE_W*k +: BYTE_W] = new_w[BYTE_W*k +: BYTE_W];
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;

  logic              accA, accB;
  logic [NB-1:0]     wrA, wrB;
  logic [ADDR_W-1:0] core_addrA;
  logic [DATA_W-1:0] core_dA, oldA, oldB, retA, retB;

  assign ready_o = (state == ST_RDY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_RST;
      init_cnt <= '0;
    end else begin
      case (state)
        ST_RST:  state <= (INIT_ZERO != 0) ? ST_INIT : ST_RDY;
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == '1) state <= ST_RDY;
        end
        default: state <= ST_RDY;
      endcase
    end
  end

  // Port A's write path doubles as the zero-fill sweep while initialising.
  // On a same-address double write B loses every byte A also enables, and
  // each write-first return reflects only the bytes that port actually wrote.
  always_comb begin
    accA       = ready_o && enA_i;
    accB       = ready_o && enB_i;
    wrA        = accA ? weA_i : '0;
    wrB        = accB ? weB_i : '0;
    if (accA && accB && (addrA_i == addrB_i)) wrB = wrB & ~wrA;
    core_addrA = addrA_i;
    core_dA    = dA_i;
    if (state == ST_INIT) begin
      wrA        = '1;
      core_addrA = init_cnt;
      core_dA    = '0;
    end
    retA = (WRITE_FIRST != 0) ? byte_merge(oldA, dA_i, wrA) : oldA;
    retB = (WRITE_FIRST != 0) ? byte_merge(oldB, dB_i, wrB) : oldB;
  end

  iob_ram_tdp_be_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk_i   (clk_i),
    .weA_i   (wrA),
    .addrA_i (core_addrA),
    .dA_i    (core_dA),
    .rdA_o   (oldA),
    .weB_i   (wrB),
    .addrB_i (addrB_i),
    .dB_i    (dB_i),
    .rdB_o   (oldB)
  );

  logic              vA1, vB1;
  logic [DATA_W-1:0] dA1, dB1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vA1 <= 1'b0;
      vB1 <= 1'b0;
      dA1 <= '0;
      dB1 <= '0;
    end else begin
      vA1 <= accA;
      vB1 <= accB;
      if (accA) dA1 <= retA;
      if (accB) dB1 <= retB;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              vA2, vB2;
    logic [DATA_W-1:0] dA2, dB2;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vA2 <= 1'b0;
        vB2 <= 1'b0;
        dA2 <= '0;
        dB2 <= '0;
      end else begin
        vA2 <= vA1;
        vB2 <= vB1;
        if (vA1) dA2 <= dA1;
        if (vB1) dB2 <= dB1;
      end
    end

    assign validA_o = vA2;
    assign validB_o = vB2;
    assign dA_o     = dA2;
    assign dB_o     = dB2;
  end else begin : g_lat1
    assign validA_o = vA1;
    assign validB_o = vB1;
    assign dA_o     = dA1;
    assign dB_o     = dB1;
  end

endmodule
